cpu_run_monitor: RTL and testbench

- Synthesizable run monitor that attaches to the risc_cpu halt/pc/ac observation signals.
- Replaces per-program fixed-delay pass/fail checks with a cycle-accurate verdict: halt detection, expected-halt-PC compare, optional accumulator compare, timeout, and a loop-iteration counter on a watched PC.
- One instance per CPU core. Usable in every program bench and on FPGA builds, with the verdict driven to LEDs.

---
 rtl/cpu_run_monitor.sv | 199 +++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
`timescale 1ns/1ps
// cpu_run_monitor: cycle-accurate run verdict for one risc_cpu core.
// Watches halt/pc/ac and produces pass/fail, timeout, cycle and loop counts.
// Optional stall detector: define CPU_RUN_MON_STALL_DET_EN to add the
// STALL_CYCLES parameter and the stall output.
// The FSM state is visible on dbg_state (0 IDLE, 1 RUN, 2 SETTLE, 3 DONE).
module cpu_run_monitor #(
  parameter int PC_WIDTH       = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HALT_STABLE    = 2
`ifdef CPU_RUN_MON_STALL_DET_EN
  ,
  parameter int STALL_CYCLES   = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] ac,
  input  logic [PC_WIDTH-1:0]   exp_halt_pc,
  input  logic [DATA_WIDTH-1:0] exp_ac,
  input  logic                  check_ac,
  input  logic [PC_WIDTH-1:0]   watch_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  loop_hits,
  output logic [PC_WIDTH-1:0]   halt_pc,
  output logic [DATA_WIDTH-1:0] halt_ac,
`ifdef CPU_RUN_MON_STALL_DET_EN
  output logic                  stall,
`endif
  output logic [1:0]            dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
  // busy is high while a run is in progress, and done (with pass/timeout and
  // the captured values) stays valid until the next accepted start or rst.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           HS_TARGET = 4'(HALT_STABLE);

  state_e                state_q;
  logic                  busy_q, done_q, pass_q, timeout_q;
  logic [CNT_WIDTH-1:0]  cycle_q, loops_q;
  logic [PC_WIDTH-1:0]   halt_pc_q, exp_pc_q, watch_q, prev_pc_q;
  logic [DATA_WIDTH-1:0] halt_ac_q, exp_ac_q;
  logic                  check_ac_q;
  logic [3:0]            stab_q;

  logic                  active;
  logic [3:0]            stab_d;
  logic [CNT_WIDTH-1:0]  cycle_d, loops_d;
  logic                  halt_verdict, timeout_hit, stall_hit, pass_cmp, loop_hit;

`ifdef CPU_RUN_MON_STALL_DET_EN
  localparam int             SW           = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0]  STALL_TARGET = SW'(STALL_CYCLES);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_q;

  // Stall run length: consecutive halt-free cycles on the same pc.
  // prev_pc_q holds last cycle's pc; a zero count marks "no history yet".
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (halt) begin
      stall_cnt_d = '0;
    end else if ((stall_cnt_q != '0) && (pc == prev_pc_q)) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end else begin
      stall_cnt_d = SW'(1);
    end
    stall_hit = (state_q == ST_RUN) && !halt && (stall_cnt_d == STALL_TARGET);
  end

  // Stall counter and stall flag; flag is set on the verdict cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      if (start) begin
        stall_cnt_q <= '0;
        stall_q     <= 1'b0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_hit) stall_q <= 1'b1;
    end
  end

  assign stall = stall_q;
`else
  assign stall_hit = 1'b0;
`endif

  // Per-cycle decisions for RUN/SETTLE: halt stability, timeout, loop entry.
  always_comb begin
    active       = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    stab_d       = (state_q == ST_RUN) ? 4'd1 : (stab_q + 4'd1);
    halt_verdict = active && halt && (stab_d == HS_TARGET);
    timeout_hit  = active && (cycle_q == TO_LAST);
    pass_cmp     = (pc == exp_pc_q) && (!check_ac_q || (ac == exp_ac_q));
    cycle_d      = (&cycle_q) ? cycle_q : (cycle_q + CNT_WIDTH'(1));
    loop_hit     = (pc == watch_q) && (prev_pc_q != watch_q);
    loops_d      = (loop_hit && !(&loops_q)) ? (loops_q + CNT_WIDTH'(1)) : loops_q;
  end

  // Monitor FSM with registered outputs; halt verdict beats stall and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
      loops_q    <= '0;
      halt_pc_q  <= '0;
      halt_ac_q  <= '0;
      exp_pc_q   <= '0;
      exp_ac_q   <= '0;
      check_ac_q <= 1'b0;
      watch_q    <= '0;
      prev_pc_q  <= '0;
      stab_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            exp_pc_q   <= exp_halt_pc;
            exp_ac_q   <= exp_ac;
            check_ac_q <= check_ac;
            watch_q    <= watch_pc;
            // Complemented so that a run starting on watch_pc counts a hit.
            prev_pc_q  <= ~watch_pc;
            cycle_q    <= '0;
            loops_q    <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            halt_pc_q  <= '0;
            halt_ac_q  <= '0;
            stab_q     <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN, ST_SETTLE: begin
          cycle_q   <= cycle_d;
          loops_q   <= loops_d;
          prev_pc_q <= pc;
          if (halt_verdict || stall_hit || timeout_hit) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            halt_pc_q <= pc;
            halt_ac_q <= ac;
            stab_q    <= '0;
            pass_q    <= halt_verdict && pass_cmp;
            timeout_q <= !halt_verdict && !stall_hit;
          end else if (halt) begin
            state_q <= ST_SETTLE;
            stab_q  <= stab_d;
          end else begin
            // Halt glitch (or still running): back to RUN, restart stability.
            state_q <= ST_RUN;
            stab_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign loop_hits   = loops_q;
  assign halt_pc     = halt_pc_q;
  assign halt_ac     = halt_ac_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
`timescale 1ns/1ps
// Bench for cpu_run_monitor: per-cycle CPU traces are generated up front,
// a trace-level reference model predicts the verdict, the driver replays
// the trace and a negedge monitor pops the prediction when done rises.
module tb_cpu_run_monitor;

  localparam int PCW  = 5;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int TO   = 50;
  localparam int HS   = 2;
  localparam int SC   = 8;
  localparam int W    = 64;
  localparam int TLEN = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, start, halt, check_ac;
  logic [PCW-1:0] pc, exp_halt_pc, watch_pc;
  logic [DW-1:0]  ac, exp_ac;
  logic busy, done, pass, timeout, stall_w;
  logic [CW-1:0]  cycle_count, loop_hits;
  logic [PCW-1:0] halt_pc;
  logic [DW-1:0]  halt_ac;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .PC_WIDTH(PCW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO), .HALT_STABLE(HS)
`ifdef CPU_RUN_MON_STALL_DET_EN
    , .STALL_CYCLES(SC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc(pc), .ac(ac),
    .exp_halt_pc(exp_halt_pc), .exp_ac(exp_ac), .check_ac(check_ac),
    .watch_pc(watch_pc), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycle_count(cycle_count), .loop_hits(loop_hits),
    .halt_pc(halt_pc), .halt_ac(halt_ac),
`ifdef CPU_RUN_MON_STALL_DET_EN
    .stall(stall_w),
`endif
    .dbg_state(dbg_state)
  );

`ifndef CPU_RUN_MON_STALL_DET_EN
  initial stall_w = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endtask

  // {busy cycles, cycle_count, loop_hits, halt_pc, halt_ac, pass, timeout, stall}
  function automatic logic [63:0] pack_res(input int bc, input int cyc, input int hits,
                                           input logic [PCW-1:0] hpc, input logic [DW-1:0] hac,
                                           input logic p, input logic t, input logic s);
    logic [15:0] bc16, cyc16, hits16;
    bc16 = 16'(bc); cyc16 = 16'(cyc); hits16 = 16'(hits);
    return {bc16, cyc16, hits16, hpc, hac, p, t, s};
  endfunction

  // ---------------- trace and run configuration ----------------
  logic           t_halt[TLEN];
  logic [PCW-1:0] t_pc[TLEN];
  logic [DW-1:0]  t_ac[TLEN];
  logic [PCW-1:0] c_exp_pc, c_watch;
  logic [DW-1:0]  c_exp_ac;
  logic           c_chk;

  // Reference model: scan the trace for the first cycle that ends the run.
  // A halt verdict is the first cycle closing HS consecutive halt-high cycles;
  // a stall is HALT-free SC cycles on one pc; a timeout is run cycle TO-1.
  function automatic logic [63:0] model();
    int  e, kind, hits;
    bit  ok;
    logic p;
    e = TO - 1; kind = 2; hits = 0;
    for (int i = 0; i < TO; i++) begin
      ok = (i >= HS - 1);
      for (int j = 0; j < HS; j++) if (i - j < 0 || !t_halt[i - j]) ok = 0;
      if (ok) begin e = i; kind = 0; break; end
`ifdef CPU_RUN_MON_STALL_DET_EN
      ok = (i >= SC - 1);
      for (int j = 0; j < SC; j++)
        if (i - j < 0 || t_halt[i - j] || t_pc[i - j] != t_pc[i]) ok = 0;
      if (ok) begin e = i; kind = 1; break; end
`endif
    end
    for (int i = 0; i <= e; i++)
      if (t_pc[i] == c_watch && (i == 0 || t_pc[i - 1] != c_watch)) hits++;
    p = (kind == 0) && (t_pc[e] == c_exp_pc) && (!c_chk || t_ac[e] == c_exp_ac);
    return pack_res(e + 1, e + 1, hits, t_pc[e], t_ac[e], p, kind == 2, kind == 1);
  endfunction

  // ---------------- trace generators ----------------
  // Fibonacci-style program: 3 setup ops, 5 passes of a 6-op loop at 0x03,
  // tail 0x09..0x0C, HLT at 0x0C.
  task automatic gen_fib();
    int k; logic [DW-1:0] a, b, tmp;
    k = 0; a = 8'd0; b = 8'd1;
    for (int p = 0; p < 3; p++) begin t_pc[k] = 5'(p); t_ac[k] = 8'd0; t_halt[k] = 0; k++; end
    for (int it = 0; it < 5; it++) begin
      for (int p = 3; p <= 8; p++) begin t_pc[k] = 5'(p); t_ac[k] = a; t_halt[k] = 0; k++; end
      tmp = a + b; a = b; b = tmp;
    end
    for (int p = 9; p <= 12; p++) begin t_pc[k] = 5'(p); t_ac[k] = a; t_halt[k] = (p == 12); k++; end
    while (k < TLEN) begin t_pc[k] = 5'd12; t_ac[k] = a; t_halt[k] = 1; k++; end
    c_exp_pc = 5'h0C; c_exp_ac = 8'h00; c_chk = 0; c_watch = 5'h03;
  endtask

  task automatic gen_linear(input bit frozen);
    for (int i = 0; i < TLEN; i++) begin
      t_halt[i] = 0;
      t_pc[i]   = frozen ? 5'h03 : 5'(i + 7);
      t_ac[i]   = 8'(i * 3);
    end
    c_exp_pc = 5'h03; c_exp_ac = 8'h00; c_chk = 0; c_watch = 5'h03;
  endtask

  // halt high from index h onward, pc/ac increment until then and hold after
  task automatic gen_halt_at(input int h);
    for (int i = 0; i < TLEN; i++) begin
      t_halt[i] = (i >= h);
      t_pc[i]   = 5'((i < h) ? i : h);
      t_ac[i]   = 8'((i < h) ? i + 40 : h + 40);
    end
    c_exp_pc = 5'(h); c_exp_ac = 8'h00; c_chk = 0; c_watch = 5'h02;
  endtask

  task automatic gen_random();
    int h, hi; logic [PCW-1:0] p; logic [DW-1:0] a;
    h = $urandom_range(0, 70);
    c_watch = 5'($urandom); p = 5'($urandom); a = 8'($urandom);
    for (int i = 0; i < TLEN; i++) begin
      if (i >= h) t_halt[i] = 1;
      else begin
        t_halt[i] = ($urandom_range(0, 7) == 0);
        p = ($urandom_range(0, 3) == 0) ? c_watch : p + 5'd1;
        a = 8'($urandom);
      end
      t_pc[i] = p; t_ac[i] = a;
    end
    hi = (h < TLEN) ? h : TLEN - 1;
    c_exp_pc = ($urandom_range(0, 2) != 0) ? t_pc[hi] : 5'($urandom);
    c_exp_ac = ($urandom_range(0, 1) != 0) ? t_ac[hi] : 8'($urandom);
    c_chk    = 1'($urandom);
  endtask

  // ---------------- driver ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_loop_hits"}, loop_hits, 0);
    check({tag, "_halt_pc"}, halt_pc, 0);
    check({tag, "_halt_ac"}, halt_ac, 0);
    check({tag, "_stall"}, stall_w, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Replays the current trace; rst_at >= 0 aborts the run with a reset.
  task automatic run_trace(input int rst_at);
    bit seen, aborted;
    seen = 0; aborted = 0;
    if (rst_at < 0) exp_q.push_back(model());
    @(negedge clk);
    start = 1; exp_halt_pc = c_exp_pc; exp_ac = c_exp_ac; check_ac = c_chk;
    watch_pc = c_watch; halt = 0; pc = 5'h1F; ac = 8'h00;
    for (int i = 0; i < TLEN && !seen && !aborted; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (i == rst_at) begin
        start = 0; rst = 1;
        @(negedge clk);
        check_all_zero("midrun_rst");
        rst = 0; aborted = 1;
      end else begin
        halt = t_halt[i]; pc = t_pc[i]; ac = t_ac[i];
        // Configuration inputs only matter at start; scramble them mid-run.
        exp_halt_pc = 5'($urandom); exp_ac = 8'($urandom);
        check_ac = 1'($urandom); watch_pc = 5'($urandom);
        start = (i > 0) && ($urandom_range(0, 9) == 0);
      end
    end
    start = 0;
    if (!aborted) begin
      check("done_wait", seen, 1);
      repeat (3) begin
        @(negedge clk);
        halt = 1'($urandom); pc = 5'($urandom); ac = 8'($urandom);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] last_exp, act;
  bit busy_prev = 0, done_prev = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 0; done_prev = 0; busy_cnt = 0;
    end else begin
      if (busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
      act = pack_res(busy_cnt, int'(cycle_count), int'(loop_hits), halt_pc, halt_ac,
                     pass, timeout, stall_w);
      if (done && !done_prev) begin
        check("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          last_exp = exp_q.pop_front();
          check("busy_cycles", act[63:48], last_exp[63:48]);
          check("cycle_count", act[47:32], last_exp[47:32]);
          check("loop_hits",   act[31:16], last_exp[31:16]);
          check("halt_pc",     act[15:11], last_exp[15:11]);
          check("halt_ac",     act[10:3],  last_exp[10:3]);
          check("pass",        act[2],     last_exp[2]);
          check("timeout",     act[1],     last_exp[1]);
          check("stall",       act[0],     last_exp[0]);
          check("state_done",  dbg_state,  2'd3);
        end
      end else if (done) begin
        check("hold", act, last_exp);
      end
      busy_prev = busy; done_prev = done;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; start = 0; halt = 0; pc = '0; ac = '0;
    exp_halt_pc = '0; exp_ac = '0; check_ac = 0; watch_pc = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;

    gen_fib(); run_trace(-1);                              // pass, 5 loop hits
    gen_fib(); c_exp_pc = 5'h0B; run_trace(-1);            // wrong halt pc
    gen_linear(0); run_trace(-1);                          // never halts
    gen_halt_at(15); t_halt[10] = 1; run_trace(-1);        // glitch then held
    gen_halt_at(TO - 2); run_trace(-1);                    // halt-stable on timeout cycle
    gen_fib(); c_chk = 1; c_exp_ac = 8'h59;
    for (int i = 36; i < TLEN; i++) t_ac[i] = 8'h59;
    run_trace(-1);                                         // ac matches
    for (int i = 36; i < TLEN; i++) t_ac[i] = 8'h58;
    run_trace(-1);                                         // ac mismatch
    gen_fib(); run_trace(20);                              // reset mid-run
    gen_fib(); run_trace(-1);                              // normal after reset
    gen_linear(1); run_trace(-1);                          // frozen pc
    for (int r = 0; r < 30; r++) begin
      gen_random(); run_trace(-1);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks required completion", n_checks);
    $fatal(1);
  end

endmodule
